seq_shift_add_multiplier: RTL

//  Iterative radix-2 shift-add multiplier. Next generation of our fixed 4x4 array multiplier:
//  - operand width is a parameter;
//  - operands are accepted and results returned over valid/ready handshakes;
//  - one partial-product row is added per clock, so one adder row is reused instead of a full array.

---
 rtl/mult_pkg.sv | 22 ++
 rtl/mult_add_row.sv | 32 +++
 rtl/seq_shift_add_multiplier.sv | 109 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state encoding
// and the counter-width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_add_row.sv
// One reusable ripple-carry adder row; sub=1 turns it into x - y.
// sign is the MSB of the WIDTH+1-bit two's-complement result.
module mult_add_row #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             sign
);

    logic [WIDTH-1:0] w_y_eff;
    logic [WIDTH:0]   w_carry;

    assign w_y_eff    = y ^ {WIDTH{sub}};
    assign w_carry[0] = sub;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign sum[gi]       = x[gi] ^ w_y_eff[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (x[gi] & w_y_eff[gi]) | (x[gi] & w_carry[gi])
                                 | (w_y_eff[gi] & w_carry[gi]);
        end
    endgenerate

    assign cout = w_carry[WIDTH];
    // Sign of the sign-extended sum, so signed steps never overflow the row.
    assign sign = x[WIDTH-1] ^ w_y_eff[WIDTH-1] ^ w_carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier with valid/ready operand and result handshakes.
// Define MULT_SIGNED_EN for two's-complement operands and product (default: unsigned).
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;

    logic               w_last;
    logic               w_sub;
    logic [WIDTH-1:0]   w_y;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic               w_sign;
    logic               w_ext;

    assign w_last = (r_count == CW'(WIDTH - 1));
    // Signed build: the multiplier MSB has negative weight, so its row subtracts.
    assign w_sub  = SIGNED_MODE && w_last && r_mplier[0];
    assign w_y    = r_mplier[0] ? r_mcand : '0;
    assign w_ext  = SIGNED_MODE ? w_sign : w_cout;

    mult_add_row #(
        .WIDTH (WIDTH)
    ) u_add_row (
        .x    (r_acc[2*WIDTH-1:WIDTH]),
        .y    (w_y),
        .sub  (w_sub),
        .sum  (w_sum),
        .cout (w_cout),
        .sign (w_sign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = CALC;
            CALC:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                CALC: begin
                    r_acc    <= {w_ext, w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == CALC);
    assign out_valid = (r_state == DONE);
    assign product   = r_acc;

endmodule
